wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset; synchronous, active-low (rst=0 resets on the clk edge).
REQ-003 SHALL have ex_wen_i  input  1  single-cycle EX result write enable.
REQ-004 SHALL have ex_waddr_i  input  5  EX destination register.
REQ-005 SHALL have ex_wdata_i  input  32  EX result.
REQ-006 SHALL have issue_i  input  1  long-latency op (load/mul/div) issued this cycle.
REQ-007 SHALL have issue_rd_i  input  5  destination of the issued long-latency op.
REQ-008 SHALL have lsu_valid_i  input  1  long-latency result valid.
REQ-009 SHALL have lsu_waddr_i  input  5  long-latency result destination.
REQ-010 SHALL have lsu_wdata_i  input  32  long-latency result data.
REQ-011 SHALL have lsu_ready_o  output  1  result accepted when lsu_valid_i and lsu_ready_o are both 1.
REQ-012 SHALL have id_rs1_i, id_rs2_i  input  5 each  decode source registers.
REQ-013 SHALL have stall_o  output  1  decode hazard stall.
REQ-014 SHALL have reg_wen_o, reg_waddr_o[4:0], reg_wdata_o[31:0]  output  register-file write port.
REQ-015 SHALL have err_o  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL hold a 2-entry FIFO of {addr[4:0], data[31:0]} for accepted long-latency results.
REQ-017 SHALL hold a 32-bit pending vector; bit 0 is always 0.
REQ-018 SHALL drive lsu_ready_o = (FIFO count < 2), from registered count only, with no same-cycle pass-through when full.
REQ-019 SHALL, on an accepted result with lsu_waddr_i=0, consume it without enqueueing.
REQ-020 SHALL, on an accepted result with nonzero address, enqueue it; the earliest regfile write is the next cycle.
REQ-021 Port arbitration (combinational): if ex_wen_i=1 and ex_waddr_i!=0, SHALL drive EX values onto reg_*; EX has absolute priority.
REQ-022 Otherwise, if the FIFO is non-empty, SHALL drive the FIFO head onto reg_* with reg_wen_o=1 and pop the head on the clock edge.
REQ-023 Otherwise SHALL drive reg_wen_o=0, reg_waddr_o=0 and reg_wdata_o=0.
REQ-024 An EX write to x0 SHALL NOT occupy the port, so the FIFO drains that cycle.
REQ-025 SHALL support simultaneous push and pop in one cycle, leaving the count unchanged; FIFO pointers wrap modulo 2.
REQ-026 issue_i=1 with issue_rd_i!=0 SHALL set pending[issue_rd_i] on the next edge.
REQ-027 A FIFO pop SHALL clear pending[head addr] on the edge.
REQ-028 If a set and a clear hit the same bit in one cycle, the set SHALL win.
REQ-029 SHALL drive stall_o=1 when any of the following holds:
- pending[id_rs1_i] is set, id_rs1_i!=0, and it is not being popped this cycle;
- the same condition holds for id_rs2_i;
- issue_i=1 and pending[issue_rd_i] is set (WAW).
REQ-030 Same-cycle pop exclusion from stall is valid because the regfile forwards same-cycle writes.
REQ-031 SHALL set err_o, holding it until reset, on either condition:
- EX write (nonzero address) to a pending register;
- accepted result with nonzero address whose pending bit is clear and which does not match an entry already in the FIFO.
REQ-032 err_o SHALL NOT alter the data path.

Reset
REQ-033 While rst=0 at a clk edge: FIFO emptied, pointers and count=0, pending=0, err_o=0.
REQ-034 While rst=0: reg_wen_o=0, lsu_ready_o=0, stall_o=0, regardless of inputs.
REQ-035 Reset asserted mid-operation SHALL discard queued results without writing them.
REQ-036 First cycle after rst returns to 1: lsu_ready_o=1, reg_wen_o follows ex_wen_i only.

Verification
REQ-037 issue_i rd=5; next cycle id_rs1=5 -> stall_o=1; lsu result (5, 0xDEADBEEF) accepted -> next cycle reg_wen_o=1, addr 5, data 0xDEADBEEF, stall_o=0 that same cycle; pending[5] clear after.
REQ-038 FIFO holds 1 entry, EX writes x7 for 3 cycles, lsu pushes 1 more -> count 2, lsu_ready_o=0; EX stops -> two pops on consecutive cycles, ready returns after first pop.
REQ-039 EX write to x0 with FIFO non-empty -> head written that cycle; lsu result to x0 -> accepted, no write, count unchanged.
REQ-040 issue rd=9 and a pop of addr 9 in the same cycle -> pending[9]=1 after the edge; issue rd=9 again while pending -> stall_o=1.
REQ-041 EX write x4 while pending[4]=1 -> err_o=1 and stays 1; rst=0 one cycle -> err_o=0, FIFO empty, no write of queued data.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
//   Bundles every non-clock/reset signal of wb_arbiter.
//   slave  : the arbiter's view (EX / long-latency / decode inputs in,
//            regfile write port, ready, stall and error flag out).
//   master : the environment's view (directions mirrored).
//   Ports:
//     ex_wen_i/ex_waddr_i/ex_wdata_i       single-cycle EX result
//     issue_i/issue_rd_i                   long-latency op issued
//     lsu_valid_i/lsu_waddr_i/lsu_wdata_i  long-latency result
//     lsu_ready_o                          long-latency result accepted
//     id_rs1_i/id_rs2_i                    decode source registers
//     stall_o                              decode hazard stall
//     reg_wen_o/reg_waddr_o/reg_wdata_o    register-file write port
//     err_o                                sticky protocol error
interface wb_arbiter_if;
  logic        ex_wen_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_ready_o;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        stall_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        err_o;

  modport slave (
    input  ex_wen_i, ex_waddr_i, ex_wdata_i,
    input  issue_i, issue_rd_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  id_rs1_i, id_rs2_i,
    output lsu_ready_o, stall_o,
    output reg_wen_o, reg_waddr_o, reg_wdata_o,
    output err_o
  );

  modport master (
    output ex_wen_i, ex_waddr_i, ex_wdata_i,
    output issue_i, issue_rd_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output id_rs1_i, id_rs2_i,
    input  lsu_ready_o, stall_o,
    input  reg_wen_o, reg_waddr_o, reg_wdata_o,
    input  err_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Register-file write-back arbiter. EX results own the single write port
//   whenever they target a nonzero register; long-latency results are parked
//   in a 2-entry FIFO and drained on any cycle the port is free. A pending
//   scoreboard tracks outstanding long-latency destinations and produces
//   the decode stall. err_o latches protocol violations (EX write to a
//   pending register, or an unexpected long-latency result) and never
//   affects the data path.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-low reset
//     bus  wb_arbiter_if.slave (see the interface header for the signals)
module wb_arbiter (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  logic [4:0]  r_fifo_addr [2];
  logic [31:0] r_fifo_data [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_pending;
  logic        r_err;

  logic        w_fifo_empty;
  logic        w_ready;
  logic        w_ex_port;
  logic        w_pop;
  logic        w_accept;
  logic        w_push;
  logic [4:0]  w_head_addr;
  logic [31:0] w_head_data;
  logic [1:0]  w_entry_match;
  logic [31:0] w_set_vec;
  logic [31:0] w_clr_vec;
  logic [31:0] w_pending_next;
  logic        w_rs1_hz;
  logic        w_rs2_hz;
  logic        w_waw_hz;
  logic        w_err_ex;
  logic        w_err_lsu;

  assign w_fifo_empty = (r_count == 2'd0);
  // Ready depends only on the registered count: a full FIFO refuses even
  // if it is draining this cycle. Held low while in reset.
  assign w_ready      = rst & (r_count < 2'd2);
  // An EX write to x0 is a no-op and leaves the port to the FIFO.
  assign w_ex_port    = bus.ex_wen_i & (bus.ex_waddr_i != 5'd0);
  assign w_head_addr  = r_fifo_addr[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];
  assign w_pop        = rst & ~w_ex_port & ~w_fifo_empty;
  assign w_accept     = bus.lsu_valid_i & w_ready;
  // Results for x0 are accepted and silently dropped.
  assign w_push       = w_accept & (bus.lsu_waddr_i != 5'd0);

  // Address match against the entries currently held in the FIFO; with two
  // slots an entry is live if the FIFO is full, or it is the head of a
  // single-entry FIFO.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic w_live;
      assign w_live = (r_count == 2'd2) |
                      ((r_count == 2'd1) & (r_rd_ptr == 1'(gi)));
      assign w_entry_match[gi] = w_live & (r_fifo_addr[gi] == bus.lsu_waddr_i);
    end
  endgenerate

  assign w_set_vec = (bus.issue_i && bus.issue_rd_i != 5'd0) ?
                     (32'd1 << bus.issue_rd_i) : 32'd0;
  assign w_clr_vec = w_pop ? (32'd1 << w_head_addr) : 32'd0;
  // Set is applied after clear so a same-cycle issue wins; x0 never pends.
  assign w_pending_next = ((r_pending & ~w_clr_vec) | w_set_vec) & ~32'd1;

  // A source being written this cycle is not a hazard: the regfile
  // forwards same-cycle writes to the read ports.
  assign w_rs1_hz = r_pending[bus.id_rs1_i] & (bus.id_rs1_i != 5'd0) &
                    ~(w_pop & (w_head_addr == bus.id_rs1_i));
  assign w_rs2_hz = r_pending[bus.id_rs2_i] & (bus.id_rs2_i != 5'd0) &
                    ~(w_pop & (w_head_addr == bus.id_rs2_i));
  assign w_waw_hz = bus.issue_i & r_pending[bus.issue_rd_i];

  assign w_err_ex  = w_ex_port & r_pending[bus.ex_waddr_i];
  assign w_err_lsu = w_push & ~r_pending[bus.lsu_waddr_i] & ~(|w_entry_match);

  assign bus.lsu_ready_o = w_ready;
  assign bus.stall_o     = rst & (w_rs1_hz | w_rs2_hz | w_waw_hz);
  assign bus.err_o       = r_err;

  // Write-port mux: EX first, then FIFO head, otherwise idle zeros.
  always_comb begin
    bus.reg_wen_o   = 1'b0;
    bus.reg_waddr_o = 5'd0;
    bus.reg_wdata_o = 32'd0;
    if (rst) begin
      if (w_ex_port) begin
        bus.reg_wen_o   = 1'b1;
        bus.reg_waddr_o = bus.ex_waddr_i;
        bus.reg_wdata_o = bus.ex_wdata_i;
      end else if (!w_fifo_empty) begin
        bus.reg_wen_o   = 1'b1;
        bus.reg_waddr_o = w_head_addr;
        bus.reg_wdata_o = w_head_data;
      end
    end
  end

  // FIFO storage carries no reset; validity comes from r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.lsu_waddr_i;
      r_fifo_data[r_wr_ptr] <= bus.lsu_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_pending <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count   <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_pending <= w_pending_next;
      if (w_err_ex | w_err_lsu) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  // Reference state: queue of parked results, pending set, error flag.
  ent_t     mq[$];
  bit [31:0] mpend = '0;
  bit        merr = 1'b0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference update on each edge, from the rules of the block.
  always @(posedge clk) begin
    bit   ex_port, acc, pop, hit;
    ent_t h;
    if (!rst) begin
      mq.delete();
      mpend = '0;
      merr  = 1'b0;
    end else begin
      ex_port = bus.ex_wen_i && bus.ex_waddr_i != 0;
      acc     = bus.lsu_valid_i && mq.size() < 2;
      pop     = !ex_port && mq.size() > 0;
      hit     = 1'b0;
      foreach (mq[k]) if (mq[k].a == bus.lsu_waddr_i) hit = 1'b1;
      if (ex_port && mpend[bus.ex_waddr_i]) merr = 1'b1;
      if (acc && bus.lsu_waddr_i != 0 && !mpend[bus.lsu_waddr_i] && !hit) merr = 1'b1;
      if (pop) begin
        h = mq.pop_front();
        mpend[h.a] = 1'b0;
      end
      if (acc && bus.lsu_waddr_i != 0) mq.push_back('{a: bus.lsu_waddr_i, d: bus.lsu_wdata_i});
      if (bus.issue_i && bus.issue_rd_i != 0) mpend[bus.issue_rd_i] = 1'b1;
    end
  end

  // Per-cycle compare of every output against the reference.
  always @(negedge clk) begin
    bit          ex_port, pop, e_ready, e_wen, e_stall, hz1, hz2, waw;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    #2;
    if (chk_en) begin
      ex_port = bus.ex_wen_i && bus.ex_waddr_i != 0;
      pop     = rst && !ex_port && mq.size() > 0;
      e_ready = rst && mq.size() < 2;
      e_wen = 1'b0; e_addr = '0; e_data = '0;
      if (rst && ex_port) begin
        e_wen = 1'b1; e_addr = bus.ex_waddr_i; e_data = bus.ex_wdata_i;
      end else if (rst && mq.size() > 0) begin
        e_wen = 1'b1; e_addr = mq[0].a; e_data = mq[0].d;
      end
      hz1 = mpend[bus.id_rs1_i] && bus.id_rs1_i != 0 && !(pop && mq[0].a == bus.id_rs1_i);
      hz2 = mpend[bus.id_rs2_i] && bus.id_rs2_i != 0 && !(pop && mq[0].a == bus.id_rs2_i);
      waw = bus.issue_i && mpend[bus.issue_rd_i];
      e_stall = rst && (hz1 || hz2 || waw);
      cmp("m_ready", bus.lsu_ready_o, e_ready);
      cmp("m_wen",   bus.reg_wen_o,   e_wen);
      cmp("m_waddr", bus.reg_waddr_o, e_addr);
      cmp("m_wdata", bus.reg_wdata_o, e_data);
      cmp("m_stall", bus.stall_o,     e_stall);
      cmp("m_err",   bus.err_o,       merr);
    end
  end

  task automatic idle();
    bus.ex_wen_i = 0; bus.ex_waddr_i = 0; bus.ex_wdata_i = 0;
    bus.issue_i = 0; bus.issue_rd_i = 0;
    bus.lsu_valid_i = 0; bus.lsu_waddr_i = 0; bus.lsu_wdata_i = 0;
    bus.id_rs1_i = 0; bus.id_rs2_i = 0;
  endtask

  // Advance to the drive point of the next cycle with quiet inputs.
  task automatic step();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic ex(logic [4:0] a, logic [31:0] d);
    bus.ex_wen_i = 1; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
  endtask

  task automatic lsu(logic [4:0] a, logic [31:0] d);
    bus.lsu_valid_i = 1; bus.lsu_waddr_i = a; bus.lsu_wdata_i = d;
  endtask

  task automatic iss(logic [4:0] rd);
    bus.issue_i = 1; bus.issue_rd_i = rd;
  endtask

  task automatic port(string n, logic wen, logic [4:0] a, logic [31:0] d);
    cmp({n, "_wen"},   bus.reg_wen_o,   wen);
    cmp({n, "_waddr"}, bus.reg_waddr_o, a);
    cmp({n, "_wdata"}, bus.reg_wdata_o, d);
  endtask

  initial begin
    idle();
    rst = 0;
    @(posedge clk);
    #1 chk_en = 1;
    // Reset holds outputs low regardless of inputs.
    step(); rst = 0; ex(3, 32'h1234); lsu(6, 32'h66); iss(2);
    #2;
    cmp("rst_wen", bus.reg_wen_o, 0);
    cmp("rst_ready", bus.lsu_ready_o, 0);
    cmp("rst_stall", bus.stall_o, 0);
    cmp("rst_err", bus.err_o, 0);

    // Load to x5 with a dependent decode.
    step(); rst = 1; iss(5);
    #2; cmp("a_ready", bus.lsu_ready_o, 1); port("a", 0, 0, 0);
    step(); bus.id_rs1_i = 5; lsu(5, 32'hDEADBEEF);
    #2; cmp("a_stall_pend", bus.stall_o, 1);
    step(); bus.id_rs1_i = 5;
    #2; port("a_wb", 1, 5, 32'hDEADBEEF); cmp("a_stall_fwd", bus.stall_o, 0);
    step(); bus.id_rs1_i = 5;
    #2; cmp("a_stall_clr", bus.stall_o, 0); port("a_idle", 0, 0, 0);

    // FIFO fills behind EX and drains when EX stops.
    step(); iss(10);
    step(); iss(11);
    step(); lsu(10, 32'hA);
    step(); ex(7, 32'h77); lsu(11, 32'hB);
    #2; cmp("b_ready1", bus.lsu_ready_o, 1); port("b_ex1", 1, 7, 32'h77);
    step(); ex(7, 32'h78);
    #2; cmp("b_full", bus.lsu_ready_o, 0); port("b_ex2", 1, 7, 32'h78);
    step(); ex(7, 32'h79);
    #2; cmp("b_full2", bus.lsu_ready_o, 0);
    step();
    #2; port("b_pop1", 1, 10, 32'hA); cmp("b_ready_p1", bus.lsu_ready_o, 0);
    step();
    #2; port("b_pop2", 1, 11, 32'hB); cmp("b_ready_p2", bus.lsu_ready_o, 1);
    step();
    #2; port("b_empty", 0, 0, 0);

    // EX to x0 yields the port; result to x0 is swallowed.
    step(); iss(12);
    step(); ex(7, 32'h70); lsu(12, 32'hC);
    step(); ex(0, 32'h99); lsu(0, 32'h55);
    #2; port("c_x0", 1, 12, 32'hC); cmp("c_ready", bus.lsu_ready_o, 1);
    step(); lsu(0, 32'h56);
    #2; port("c_none", 0, 0, 0); cmp("c_ready2", bus.lsu_ready_o, 1);
    step();
    #2; port("c_drop", 0, 0, 0);

    // Re-issue of a register in the cycle its result drains.
    step(); iss(9);
    step(); ex(7, 32'h71); lsu(9, 32'h9);
    step(); iss(9);
    #2; port("d_pop9", 1, 9, 32'h9); cmp("d_waw0", bus.stall_o, 1);
    step(); iss(9); bus.id_rs2_i = 9;
    #2; cmp("d_waw1", bus.stall_o, 1);

    // EX write to a pending register; reset discards the queue.
    step(); iss(4);
    step(); iss(13);
    step(); ex(7, 32'h72); lsu(13, 32'hD);
    step(); ex(4, 32'h44);
    #2; port("e_ex4", 1, 4, 32'h44); cmp("e_err0", bus.err_o, 0);
    step(); ex(7, 32'h73);
    #2; cmp("e_err1", bus.err_o, 1);
    step(); rst = 0; lsu(20, 32'h20);
    #2; cmp("e_err_hold", bus.err_o, 1); port("e_rst", 0, 0, 0);
    cmp("e_rst_ready", bus.lsu_ready_o, 0);
    step(); rst = 1; bus.id_rs1_i = 4;
    #2; cmp("e_err_clr", bus.err_o, 0); port("e_flushed", 0, 0, 0);
    cmp("e_ready", bus.lsu_ready_o, 1); cmp("e_stall", bus.stall_o, 0);

    // Randomized traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 149) != 0);
      bus.ex_wen_i    = ($urandom_range(0, 9) < 4);
      bus.ex_waddr_i  = 5'($urandom_range(0, 15));
      bus.ex_wdata_i  = $urandom;
      bus.issue_i     = ($urandom_range(0, 9) < 3);
      bus.issue_rd_i  = 5'($urandom_range(0, 15));
      bus.lsu_valid_i = ($urandom_range(0, 9) < 4);
      bus.lsu_waddr_i = 5'($urandom_range(0, 15));
      bus.lsu_wdata_i = $urandom;
      bus.id_rs1_i    = 5'($urandom_range(0, 15));
      bus.id_rs2_i    = 5'($urandom_range(0, 15));
    end

    step();
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
